// File: rtl/clock_control.sv
// SAP-1 clock control: turns the debounced STEP button, the run switch and the CPU HLT
// into a one-cycle CPU clock-enable. Define STEP_AUTOREPEAT_EN for auto-repeat of a held step.
module clock_control #(
   parameter int DIV_WIDTH    = 24,
   parameter int RUN_DIV      = 1000,
   parameter int REPEAT_DELAY = 500000,
   parameter int REPEAT_RATE  = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step_n_i,
   input  logic       run_mode_i,
   input  logic       hlt_i,
   output logic       cpu_en_o,
   output logic       halted_o,
   output logic       running_o,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      ST_STEP = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(RUN_DIV - 1);

   state_t               state;
   logic [DIV_WIDTH-1:0] div;
   logic                 step_q;
   logic                 press;
   logic                 rpt_fire;

   assign press     = step_q & ~step_n_i;
   assign dbg_state = state;

`ifdef STEP_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic [RPT_W-1:0] rpt_target;
   logic             rpt_armed;
   logic             rpt_first;

   // rpt_cnt counts cycles since the last pulse of the current hold; first gap is the long delay.
   assign rpt_target = rpt_first ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_RATE);
   assign rpt_fire   = rpt_armed & ~step_n_i & ~press & (rpt_cnt == rpt_target);

   always_ff @(posedge clk) begin
      if (rst || hlt_i || state != ST_STEP || run_mode_i || step_n_i) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b0;
         rpt_first <= 1'b1;
      end else if (press) begin
         rpt_cnt   <= RPT_W'(1);
         rpt_armed <= 1'b1;
         rpt_first <= 1'b1;
      end else if (rpt_armed) begin
         if (rpt_cnt == rpt_target) begin
            rpt_cnt   <= RPT_W'(1);
            rpt_first <= 1'b0;
         end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
         end
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_STEP;
         div       <= '0;
         step_q    <= 1'b1;
         cpu_en_o  <= 1'b0;
         halted_o  <= 1'b0;
         running_o <= 1'b0;
      end else begin
         step_q   <= step_n_i;
         cpu_en_o <= 1'b0;
         // HLT wins over everything, including a pulse that was due this cycle.
         if (hlt_i) begin
            state     <= ST_HALT;
            div       <= '0;
            halted_o  <= 1'b1;
            running_o <= 1'b0;
         end else begin
            case (state)
               ST_STEP: begin
                  if (run_mode_i) begin
                     state     <= ST_RUN;
                     div       <= '0;
                     running_o <= 1'b1;
                  end else if (press || rpt_fire) begin
                     cpu_en_o <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (!run_mode_i) begin
                     state     <= ST_STEP;
                     div       <= '0;
                     running_o <= 1'b0;
                  end else if (div == DIV_LAST) begin
                     div      <= '0;
                     cpu_en_o <= 1'b1;
                  end else begin
                     div <= div + 1'b1;
                  end
               end
               ST_HALT: begin
                  state <= ST_HALT;
               end
               default: begin
                  state     <= ST_STEP;
                  div       <= '0;
                  running_o <= 1'b0;
                  halted_o  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clock_control.sv
// Directed bench for clock_control: expected pulse cycles are queued as stimulus is
// driven and matched against every cpu_en_o pulse; level outputs are checked inline.
module tb_clock_control;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       step_n = 1'b1;
   logic       run_mode = 1'b0;
   logic       hlt = 1'b0;
   logic       cpu_en;
   logic       halted;
   logic       running;
   logic [1:0] dbg_state;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int last_pulse = -10;
   int c;
   logic [31:0] exp_q[$];

   localparam logic [1:0] S_STEP = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   clock_control #(
      .DIV_WIDTH(8),
      .RUN_DIV(4),
      .REPEAT_DELAY(8),
      .REPEAT_RATE(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .step_n_i(step_n),
      .run_mode_i(run_mode),
      .hlt_i(hlt),
      .cpu_en_o(cpu_en),
      .halted_o(halted),
      .running_o(running),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges so far; outputs of edge k are observed with cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cpu_en === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0)
         else begin
            errors++;
            $error("FAIL pulse_unexpected: pulse at cycle %0d, none required", cyc);
         end
         if (exp_q.size() != 0) begin
            logic [31:0] exp;
            exp = exp_q.pop_front();
            checks++;
            assert (32'(cyc) === exp)
            else begin
               errors++;
               $error("FAIL pulse_cycle: pulse at cycle %0d, required %0d", cyc, exp);
            end
         end
         checks++;
         assert (cyc - last_pulse > 1)
         else begin
            errors++;
            $error("FAIL pulse_back_to_back: pulse at %0d follows pulse at %0d", cyc, last_pulse);
         end
         last_pulse = cyc;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0d required %0d", tag, got, exp);
      end
   endtask

   task automatic drain(input string tag);
      checks++;
      assert (exp_q.size() === 0)
      else begin
         errors++;
         $error("FAIL %s: %0d expected pulses missing, required 0", tag, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic chk_levels(input string tag, input logic h, input logic r, input logic [1:0] s);
      chk({tag, "_halted"}, 32'(halted), 32'(h));
      chk({tag, "_running"}, 32'(running), 32'(r));
      chk({tag, "_state"}, 32'(dbg_state), 32'(s));
   endtask

   initial begin
      // Reset held two cycles, then twenty idle cycles with no pulses.
      rst = 1'b1;
      tick(2);
      chk("reset_cpu_en", 32'(cpu_en), 32'd0);
      chk_levels("reset", 1'b0, 1'b0, S_STEP);
      rst = 1'b0;
      tick(20);
      chk_levels("idle", 1'b0, 1'b0, S_STEP);
      drain("idle");

      // Held step press: one pulse the cycle after the press (plus repeats with auto-repeat).
      c = cyc;
      step_n = 1'b0;
      exp_q.push_back(32'(c + 1));
`ifdef STEP_AUTOREPEAT_EN
      for (int p = c + 9; p <= c + 30; p += 3) exp_q.push_back(32'(p));
`endif
      tick(30);
      step_n = 1'b1;
      tick(5);
      drain("step_hold");

      // Short second press.
      c = cyc;
      step_n = 1'b0;
      exp_q.push_back(32'(c + 1));
      tick(2);
      step_n = 1'b1;
      tick(4);
      drain("step_again");

      // Enter RUN, one pulse, then back to STEP before the second one is due.
      c = cyc;
      run_mode = 1'b1;
      exp_q.push_back(32'(c + 5));
      tick(1);
      chk_levels("run_entry", 1'b0, 1'b1, S_RUN);
      tick(5);
      run_mode = 1'b0;
      tick(1);
      chk_levels("run_exit", 1'b0, 1'b0, S_STEP);
      tick(6);
      drain("run_exit");

      // HLT arriving when the divider is about to wrap suppresses the pulse.
      c = cyc;
      run_mode = 1'b1;
      tick(4);
      hlt = 1'b1;
      tick(1);
      chk("halt_cpu_en", 32'(cpu_en), 32'd0);
      chk_levels("halt_entry", 1'b1, 1'b0, S_HALT);
      hlt = 1'b0;
      run_mode = 1'b0;
      tick(3);
      run_mode = 1'b1;
      tick(3);
      step_n = 1'b0;
      tick(3);
      step_n = 1'b1;
      run_mode = 1'b0;
      tick(3);
      chk_levels("halt_sticky", 1'b1, 1'b0, S_HALT);
      drain("halt");

      // Reset while halted.
      rst = 1'b1;
      tick(1);
      chk("rst_halt_cpu_en", 32'(cpu_en), 32'd0);
      chk_levels("rst_halt", 1'b0, 1'b0, S_STEP);
      rst = 1'b0;
      tick(3);
      drain("rst_halt");

      // Reset in RUN on the cycle a pulse would have been produced.
      run_mode = 1'b1;
      tick(4);
      rst = 1'b1;
      run_mode = 1'b0;
      tick(1);
      chk("rst_run_cpu_en", 32'(cpu_en), 32'd0);
      chk_levels("rst_run", 1'b0, 1'b0, S_STEP);
      rst = 1'b0;
      tick(3);
      drain("rst_run");

      // Presses during RUN leave the 4-cycle pulse train untouched.
      c = cyc;
      run_mode = 1'b1;
      for (int k = 0; k < 4; k++) exp_q.push_back(32'(c + 5 + 4 * k));
      tick(6);
      step_n = 1'b0;
      tick(2);
      step_n = 1'b1;
      tick(2);
      step_n = 1'b0;
      tick(8);
      run_mode = 1'b0;
      step_n = 1'b1;
      tick(3);
      chk_levels("run_press_end", 1'b0, 1'b0, S_STEP);
      drain("run_press");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
